dcache_responder: RTL and testbench
===================================

// Module: dcache_responder
// PURPOSE
//  Direct-mapped, write-back, one-word-per-line data cache: the responder end of the MEM-stage dmemREN/dmemWEN/dhit protocol.
//  Sits between the EX/MEM latch (which stalls while a request is pending and dhit=0) and the memory arbiter (dREN/dWEN/dwait).
//  On halt, flushes all dirty lines to memory and then asserts flushed.
// PARAMETERS
//  SETS    16   number of lines, power of 2; IDX_W = $clog2(SETS)
//  ADDR_W  32   word-address bus width; TAG_W = ADDR_W-IDX_W-2
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       reset, asynchronous, active-low
//  dmemREN    in   1       CPU load request; held stable until dhit
//  dmemWEN    in   1       CPU store request; held stable until dhit; never both with dmemREN
//  dmemaddr   in   ADDR_W  CPU byte address; [1:0] ignored
//  dmemstore  in   32      CPU store data
//  halt       in   1       CPU halted; start flush
//  dhit       out  1       request satisfied this cycle
//  dmemload   out  32      load data, valid while dhit && dmemREN
//  flushed    out  1       flush complete; sticky until reset
//  dREN       out  1       memory read request
//  dWEN       out  1       memory write request
//  daddr      out  ADDR_W  memory word address ([1:0]=0)
//  dstore     out  32      memory write data
//  dload      in   32      memory read data, valid when dREN && !dwait
//  dwait      in   1       memory busy; transfer completes in a cycle with dwait=0
// BEHAVIOUR
//  - Reset: state IDLE; all valid/dirty bits 0; dhit, dREN, dWEN, flushed = 0; daddr, dstore, dmemload = 0. Tag/data arrays need not reset.
//  - Address split: index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2].
//  - hit = valid[idx] && tag[idx]==req tag && (dmemREN||dmemWEN) && state==IDLE. dhit = hit, combinational (0-cycle hit latency).
//  - Read hit: dmemload = data[idx] same cycle; no state change.
//  - Write hit: at the edge, data[idx] <= dmemstore, dirty[idx] <= 1; dhit high that cycle.
//  - FSM states: IDLE, WB, FETCH, FLUSH, DONE.
//  - IDLE, request miss: dirty victim -> WB; else -> FETCH. No request and halt=1 -> FLUSH, idx counter = 0.
//  - Request and halt in the same cycle: request served first; flush starts only from IDLE with no request.
//  - WB: dWEN=1, daddr={victim tag, idx, 2'b00}, dstore=data[idx]; hold until dwait=0, then dirty[idx]<=0, -> FETCH.
//  - FETCH: dREN=1, daddr={req addr[ADDR_W-1:2],2'b00}; on dwait=0 write dload to data, tag, valid=1, dirty=0, -> IDLE.
//    Refill of a write miss still fetches; the store then hits in IDLE next cycle (miss penalty = WB + FETCH + 1).
//  - dREN and dWEN never both 1; both 0 in IDLE and DONE.
//  - FLUSH: walk idx 0..SETS-1; dirty line -> dWEN with its address/data, advance on dwait=0 and clear dirty; clean line advances in 1 cycle.
//    After idx SETS-1 -> DONE. Counter wraps exactly once; no line skipped or repeated.
//  - DONE: flushed=1, dhit=0, terminal until reset.
//  - Reset mid-WB/FETCH/FLUSH: immediate return to IDLE, bus requests drop asynchronously, partial line discarded.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds outputs hit_count[31:0], miss_count[31:0]; reset 0;
//    hit_count +1 per cycle IDLE has hit on a request that was not just refilled; miss_count +1 per IDLE->WB/FETCH transition; saturate at 2^32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  cpu_types_pkg: word_t (32b), dcache_state_t enum {IDLE,WB,FETCH,FLUSH,DONE}, dcache_line_t struct {valid,dirty,tag,data}.
//  Local params IDX_W/TAG_W derived in module. One sub-module natural: dcache_array (SETS x dcache_line_t storage,
//  1 comb read port by index, 1 sync write port, async valid/dirty clear on nRST).
// TESTING
//  1 Cold read 0x40, memory returns 0xDEADBEEF after 2 dwait cycles -> FETCH 3 cycles, then dhit=1, dmemload=0xDEADBEEF, dREN never with dWEN.
//  2 Store 0x12345678 to 0x40 (resident) -> dhit same cycle, no bus traffic; reload 0x40 -> 0x12345678.
//  3 Dirty 0x40, then read 0x80 (same index, SETS=16) -> WB daddr=0x40 dstore=0x12345678, then FETCH daddr=0x80, then dhit.
//  4 Dirty sets 0,3,15 then halt -> exactly 3 dWEN transfers in ascending index order, then flushed=1 held; dhit stays 0.
//  5 Halt asserted with pending miss -> miss completes with dhit before first flush write.
//  6 nRST low during FETCH with dwait=1 -> dREN falls without clock; after release, read of same address misses again.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the data cache responder.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FETCH,
        FLUSH,
        DONE
    } dcache_state_t;

    // Tag is stored word-wide and zero-extended so the line layout is independent of SETS/ADDR_W.
    typedef struct packed {
        logic  valid;
        logic  dirty;
        word_t tag;
        word_t data;
    } dcache_line_t;

endpackage

// File: rtl/dcache_responder_if.sv
// CPU-side request/response and memory-arbiter bus of the data cache responder.
// With DCACHE_STATS_EN defined the bus also carries hit_count/miss_count.
interface dcache_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    import cpu_types_pkg::*;

    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    word_t             dmemstore;
    logic              halt;
    logic              dhit;
    word_t             dmemload;
    logic              flushed;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    word_t             dstore;
    word_t             dload;
    logic              dwait;
`ifdef DCACHE_STATS_EN
    word_t             hit_count;
    word_t             miss_count;
`endif

    // Cache side
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
`ifdef DCACHE_STATS_EN
        , output hit_count, miss_count
`endif
    );

    // CPU and memory side
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
`ifdef DCACHE_STATS_EN
        , input hit_count, miss_count
`endif
    );

endinterface

// File: rtl/dcache_array.sv
// Line storage: combinational read by index, one synchronous write port.
// Only valid/dirty are reset; tag/data are don't-care until a line is valid.
module dcache_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [$clog2(SETS)-1:0] ridx,
    output dcache_line_t            rline,
    input  logic                    we,
    input  logic [$clog2(SETS)-1:0] widx,
    input  dcache_line_t            wline
);

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;
    word_t           tag_q  [SETS];
    word_t           data_q [SETS];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[widx] <= wline.valid;
            dirty_q[widx] <= wline.dirty;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            tag_q[widx]  <= wline.tag;
            data_q[widx] <= wline.data;
        end
    end

    always_comb begin
        rline.valid = valid_q[ridx];
        rline.dirty = dirty_q[ridx];
        rline.tag   = tag_q[ridx];
        rline.data  = data_q[ridx];
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back data cache answering dmemREN/dmemWEN with a 0-cycle dhit.
// Optional DCACHE_STATS_EN adds saturating hit/miss counters on the bus.
module dcache_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32
) (
    input logic               CLK,
    input logic               nRST,
    dcache_responder_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    dcache_state_t    state_q, state_n;
    logic [IDX_W-1:0] fidx_q, fidx_n;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] ridx;
    logic [TAG_W-1:0] req_tag;
    dcache_line_t     rline;
    dcache_line_t     wline;
    logic             we;
    logic             req;
    logic             hit;
    logic             advance;

    assign req_idx = bus.dmemaddr[IDX_W+1:2];
    assign req_tag = bus.dmemaddr[ADDR_W-1:IDX_W+2];
    assign req     = bus.dmemREN || bus.dmemWEN;
    assign ridx    = (state_q == FLUSH) ? fidx_q : req_idx;
    assign hit     = (state_q == IDLE) && req && rline.valid && (rline.tag == WORD_W'(req_tag));

    dcache_array #(.SETS(SETS)) u_array (
        .CLK   (CLK),
        .nRST  (nRST),
        .ridx  (ridx),
        .rline (rline),
        .we    (we),
        .widx  (ridx),
        .wline (wline)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fidx_q  <= '0;
        end else begin
            state_q <= state_n;
            fidx_q  <= fidx_n;
        end
    end

    // Next state, array write and bus drive; everything is 0 in IDLE/DONE so reset drops requests at once.
    always_comb begin
        state_n      = state_q;
        fidx_n       = fidx_q;
        we           = 1'b0;
        wline        = rline;
        advance      = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.flushed  = 1'b0;
        bus.dhit     = hit;
        bus.dmemload = (hit && bus.dmemREN) ? rline.data : '0;

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (bus.dmemWEN) begin
                        we         = 1'b1;
                        wline.data = bus.dmemstore;
                        wline.dirty = 1'b1;
                    end
                end else if (req) begin
                    state_n = (rline.valid && rline.dirty) ? WB : FETCH;
                end else if (bus.halt) begin
                    state_n = FLUSH;
                    fidx_n  = '0;
                end
            end
            WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = {rline.tag[TAG_W-1:0], req_idx, 2'b00};
                bus.dstore = rline.data;
                if (!bus.dwait) begin
                    we          = 1'b1;
                    wline.dirty = 1'b0;
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                bus.dREN  = 1'b1;
                bus.daddr = {bus.dmemaddr[ADDR_W-1:2], 2'b00};
                if (!bus.dwait) begin
                    we          = 1'b1;
                    wline.valid = 1'b1;
                    wline.dirty = 1'b0;
                    wline.tag   = WORD_W'(req_tag);
                    wline.data  = bus.dload;
                    state_n     = IDLE;
                end
            end
            FLUSH: begin
                if (rline.valid && rline.dirty) begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = {rline.tag[TAG_W-1:0], fidx_q, 2'b00};
                    bus.dstore = rline.data;
                    if (!bus.dwait) begin
                        we          = 1'b1;
                        wline.dirty = 1'b0;
                        advance     = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (fidx_q == IDX_W'(SETS - 1)) begin
                        state_n = DONE;
                    end else begin
                        fidx_n = IDX_W'(fidx_q + 1'b1);
                    end
                end
            end
            DONE: begin
                bus.flushed = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic  refilled_q;
    word_t hit_cnt_q;
    word_t miss_cnt_q;

    // A hit straight after a refill is the tail of a miss, not a separate hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            refilled_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            refilled_q <= (state_q == FETCH) && !bus.dwait;
            if (hit && !refilled_q && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if ((state_q == IDLE) && ((state_n == WB) || (state_n == FETCH)) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus random traffic
// against an architectural memory model and a direct-mapped residency model.
module tb_dcache_responder;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    dcache_responder_if #(.ADDR_W(32)) bus ();

    dcache_responder #(.SETS(16), .ADDR_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];

    int lat = -1;
    bit started = 1'b0;
    int cnt = 0;
    int overlap = 0;
    int dren_cycles = 0;

    logic        mv [16];
    logic        md [16];
    logic [31:0] mt [16];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_val(a);
    endfunction

    function automatic void preset(input logic [31:0] a, input logic [31:0] v);
        mem[a]  = v;
        arch[a] = v;
    endfunction

    // Residency model: predicts hit, victim write-back and the architecturally correct load value.
    function automatic void model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                                         output bit hit, output bit wb, output logic [31:0] wb_a,
                                         output logic [31:0] wb_d, output logic [31:0] ld);
        int idx;
        logic [31:0] tag;
        idx  = int'(a[5:2]);
        tag  = a >> 6;
        hit  = mv[idx] && (mt[idx] == tag);
        wb   = !hit && mv[idx] && md[idx];
        wb_a = (mt[idx] << 6) | (32'(idx) << 2);
        wb_d = arch_rd(wb_a);
        ld   = arch_rd(a);
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tag;
            md[idx] = 1'b0;
        end
        if (we) begin
            md[idx] = 1'b1;
            arch[a] = d;
        end
    endfunction

    // Memory arbiter: latency `lat` (or random 0..3) per transfer; completions logged at the negedge before the edge.
    always @(negedge CLK) begin
        if (bus.dREN && bus.dWEN) overlap++;
        if (bus.dREN) dren_cycles++;
        if (bus.dREN || bus.dWEN) begin
            if (!started) begin
                started = 1'b1;
                cnt = (lat >= 0) ? lat : int'($urandom_range(0, 3));
            end
            bus.dwait = (cnt != 0);
            bus.dload = bus.dREN ? mem_rd(bus.daddr) : $urandom;
            if (cnt != 0) begin
                cnt--;
            end else begin
                started = 1'b0;
                if (nRST && bus.dWEN) begin
                    mem[bus.daddr] = bus.dstore;
                    wr_addr_q.push_back(bus.daddr);
                    wr_data_q.push_back(bus.dstore);
                end
                if (nRST && bus.dREN) rd_addr_q.push_back(bus.daddr);
            end
        end else begin
            started   = 1'b0;
            bus.dwait = 1'($urandom_range(0, 1));
            bus.dload = $urandom;
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST = 1'b0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.halt    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        arch.delete();
        foreach (mem[k]) arch[k] = mem[k];
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        clear_logs();
    endtask

    // Issues one request starting at a negedge; returns at the negedge after the hit with the request dropped.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int cyc, output bit ok);
        bus.dmemREN   = !we;
        bus.dmemWEN   = we;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        cyc = 0;
        #1;
        while (!bus.dhit && cyc < 60) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        ok    = bus.dhit;
        rdata = bus.dmemload;
        @(negedge CLK);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.dhit, bus.dREN, bus.dWEN, bus.flushed} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: dhit/dREN/dWEN/flushed=%b expected 0000", {bus.dhit, bus.dREN, bus.dWEN, bus.flushed});
        end
        checks++;
        if (bus.daddr !== 32'h0 || bus.dstore !== 32'h0 || bus.dmemload !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: daddr=%h dstore=%h dmemload=%h expected 0", bus.daddr, bus.dstore, bus.dmemload);
        end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if ({bus.dhit, bus.dREN, bus.dWEN, bus.flushed} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: dhit/dREN/dWEN/flushed=%b expected 0000", {bus.dhit, bus.dREN, bus.dWEN, bus.flushed});
        end
        @(negedge CLK);
    endtask

    task automatic test_cold_read();
        logic [31:0] rd, wa, wd, ld;
        int cyc;
        bit ok, eh, ewb;
        lat = 2;
        preset(32'h40, 32'hDEAD_BEEF);
        model_access(1'b0, 32'h40, 32'h0, eh, ewb, wa, wd, ld);
        clear_logs();
        dren_cycles = 0;
        access(1'b0, 32'h40, 32'h0, rd, cyc, ok);
        checks++;
        if (!ok || cyc != 4) begin
            errors++;
            $display("FAIL cold_read_latency: hit=%0b after %0d cycles expected hit after 4", ok, cyc);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || ld !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cold_read_data: dmemload=%h expected DEADBEEF", rd);
        end
        checks++;
        if (dren_cycles != 3 || rd_addr_q.size() != 1 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL cold_read_bus: dREN cycles=%0d reads=%0d writes=%0d expected 3/1/0", dren_cycles, rd_addr_q.size(), wr_addr_q.size());
        end else begin
            checks++;
            if (rd_addr_q[0] !== 32'h40) begin
                errors++;
                $display("FAIL cold_read_addr: daddr=%h expected 00000040", rd_addr_q[0]);
            end
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd, wa, wd, ld;
        int cyc;
        bit ok, eh, ewb;
        model_access(1'b1, 32'h40, 32'h1234_5678, eh, ewb, wa, wd, ld);
        clear_logs();
        access(1'b1, 32'h40, 32'h1234_5678, rd, cyc, ok);
        checks++;
        if (!ok || cyc != 0 || !eh || rd_addr_q.size() != 0 || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL store_hit: hit=%0b cycles=%0d reads=%0d writes=%0d expected 1/0/0/0", ok, cyc, rd_addr_q.size(), wr_addr_q.size());
        end
        model_access(1'b0, 32'h40, 32'h0, eh, ewb, wa, wd, ld);
        access(1'b0, 32'h40, 32'h0, rd, cyc, ok);
        checks++;
        if (!ok || cyc != 0 || rd !== 32'h1234_5678 || rd !== ld) begin
            errors++;
            $display("FAIL store_reload: hit=%0b cycles=%0d data=%h expected 1/0/12345678", ok, cyc, rd);
        end
    endtask

    task automatic test_writeback();
        logic [31:0] rd, wa, wd, ld;
        int cyc;
        bit ok, eh, ewb;
        lat = 1;
        model_access(1'b0, 32'h80, 32'h0, eh, ewb, wa, wd, ld);
        clear_logs();
        access(1'b0, 32'h80, 32'h0, rd, cyc, ok);
        checks++;
        if (!ok || cyc != 5) begin
            errors++;
            $display("FAIL wb_latency: hit=%0b after %0d cycles expected hit after 5", ok, cyc);
        end
        checks++;
        if (wr_addr_q.size() != 1 || !ewb) begin
            errors++;
            $display("FAIL wb_count: writes=%0d expected 1", wr_addr_q.size());
        end else begin
            checks++;
            if (wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 32'h1234_5678 || wr_addr_q[0] !== wa || wr_data_q[0] !== wd) begin
                errors++;
                $display("FAIL wb_payload: daddr=%h dstore=%h expected 00000040/12345678", wr_addr_q[0], wr_data_q[0]);
            end
        end
        checks++;
        if (rd_addr_q.size() != 1 || rd_addr_q[0] !== 32'h80 || rd !== ld) begin
            errors++;
            $display("FAIL wb_refill: reads=%0d data=%h expected 1 read of 00000080 data %h", rd_addr_q.size(), rd, ld);
        end
    endtask

    task automatic wait_flushed(input string name);
        int k = 0;
        #1;
        while (!bus.flushed && k < 400) begin
            @(negedge CLK);
            #1;
            k++;
        end
        checks++;
        if (!bus.flushed) begin
            errors++;
            $display("FAIL %s_timeout: flushed=%0b after %0d cycles expected 1", name, bus.flushed, k);
        end
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, wa, wd, ld;
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        int cyc, bad;
        bit we, ok, eh, ewb;
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            a  = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
            d  = $urandom;
            model_access(we, a, d, eh, ewb, wa, wd, ld);
            clear_logs();
            access(we, a, d, rd, cyc, ok);
            checks++;
            if (!ok || ((cyc == 0) != eh)) begin
                errors++;
                $display("FAIL rand_hit[%0d]: addr=%h hit=%0b cycles=%0d expected first-cycle hit=%0b", n, a, ok, cyc, eh);
            end
            if (!we) begin
                checks++;
                if (rd !== ld) begin
                    errors++;
                    $display("FAIL rand_load[%0d]: addr=%h data=%h expected %h", n, a, rd, ld);
                end
            end
            checks++;
            if (wr_addr_q.size() != (ewb ? 1 : 0) || (ewb && (wr_addr_q[0] !== wa || wr_data_q[0] !== wd))) begin
                errors++;
                $display("FAIL rand_wb[%0d]: writes=%0d expected %0d to %h data %h", n, wr_addr_q.size(), ewb, wa, wd);
            end
            checks++;
            if (rd_addr_q.size() != (eh ? 0 : 1) || (!eh && rd_addr_q[0] !== a)) begin
                errors++;
                $display("FAIL rand_fetch[%0d]: reads=%0d expected %0d of %h", n, rd_addr_q.size(), !eh, a);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (mv[i] && md[i]) begin
                ea.push_back((mt[i] << 6) | (32'(i) << 2));
                ed.push_back(arch_rd((mt[i] << 6) | (32'(i) << 2)));
                md[i] = 1'b0;
            end
        end
        clear_logs();
        bus.halt = 1'b1;
        wait_flushed("rand_flush");
        checks++;
        if (wr_addr_q.size() != ea.size()) begin
            errors++;
            $display("FAIL rand_flush_count: writes=%0d expected %0d", wr_addr_q.size(), ea.size());
        end
        bad = 0;
        foreach (arch[k]) if (mem_rd(k) !== arch[k]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_flush_memory: %0d words differ from stored values, expected 0", bad);
        end
    endtask

    task automatic test_halt_pending();
        logic [31:0] rd, wa, wd, ld;
        logic [31:0] st [3];
        int cyc;
        bit ok, eh, ewb;
        lat = -1;
        st[0] = 32'h100;
        st[1] = 32'h10C;
        st[2] = 32'h13C;
        for (int i = 0; i < 3; i++) begin
            model_access(1'b1, st[i], 32'hC0DE_0000 + 32'(i), eh, ewb, wa, wd, ld);
            access(1'b1, st[i], 32'hC0DE_0000 + 32'(i), rd, cyc, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dirty_store[%0d]: no dhit for %h expected dhit", i, st[i]);
            end
        end
        clear_logs();
        bus.halt = 1'b1;
        model_access(1'b0, 32'h214, 32'h0, eh, ewb, wa, wd, ld);
        access(1'b0, 32'h214, 32'h0, rd, cyc, ok);
        checks++;
        if (!ok || rd !== ld || wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL halt_pending: hit=%0b data=%h writes=%0d expected 1/%h/0", ok, rd, wr_addr_q.size(), ld);
        end
    endtask

    task automatic test_flush_order();
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        for (int i = 0; i < 16; i++) begin
            if (mv[i] && md[i]) begin
                ea.push_back((mt[i] << 6) | (32'(i) << 2));
                ed.push_back(arch_rd((mt[i] << 6) | (32'(i) << 2)));
                md[i] = 1'b0;
            end
        end
        wait_flushed("flush");
        checks++;
        if (wr_addr_q.size() != 3 || ea.size() != 3) begin
            errors++;
            $display("FAIL flush_count: writes=%0d expected 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL flush_entry[%0d]: daddr=%h dstore=%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                end
            end
        end
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (bus.flushed !== 1'b1 || bus.dhit !== 1'b0 || bus.dREN !== 1'b0 || bus.dWEN !== 1'b0) begin
                errors++;
                $display("FAIL done_hold[%0d]: flushed=%0b dhit=%0b dREN=%0b dWEN=%0b expected 1/0/0/0", i, bus.flushed, bus.dhit, bus.dREN, bus.dWEN);
            end
        end
        @(negedge CLK);
        bus.dmemREN = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] rd, wa, wd, ld;
        int cyc, k;
        bit ok, eh, ewb;
        lat = 10;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h300;
        k = 0;
        #1;
        while (!bus.dREN && k < 5) begin
            @(negedge CLK);
            #1;
            k++;
        end
        checks++;
        if (!bus.dREN) begin
            errors++;
            $display("FAIL mid_fetch_start: dREN=%0b expected 1", bus.dREN);
        end
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (bus.dREN !== 1'b0 || bus.daddr !== 32'h0) begin
            errors++;
            $display("FAIL mid_fetch_reset: dREN=%0b daddr=%h expected 0/00000000", bus.dREN, bus.daddr);
        end
        @(negedge CLK);
        bus.dmemREN = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        @(negedge CLK);
        nRST = 1'b1;
        lat = 1;
        clear_logs();
        model_access(1'b0, 32'h300, 32'h0, eh, ewb, wa, wd, ld);
        access(1'b0, 32'h300, 32'h0, rd, cyc, ok);
        checks++;
        if (!ok || eh || cyc != 3 || rd !== ld || rd_addr_q.size() != 1) begin
            errors++;
            $display("FAIL mid_fetch_remiss: hit=%0b cycles=%0d data=%h reads=%0d expected 1/3/%h/1", ok, cyc, rd, rd_addr_q.size(), ld);
        end
    endtask

    task automatic test_bus_exclusive();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL bus_exclusive: dREN&&dWEN seen in %0d cycles expected 0", overlap);
        end
    endtask

    initial begin
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;
        bus.dwait     = 1'b1;
        bus.dload     = '0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
            mt[i] = '0;
        end
        test_reset();
        test_cold_read();
        test_store_hit();
        test_writeback();
        test_random();
        apply_reset();
        test_halt_pending();
        test_flush_order();
        apply_reset();
        test_reset_mid_fetch();
        test_bus_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
        $fatal(1);
    end

endmodule
